// File: rtl/dcache_ctrl.sv
// Direct-mapped, 8 x 1-word, write-through / no-write-allocate data cache
// sitting between the EX/MEM register and a single-port backing memory.
module dcache_ctrl (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        is_mem_inst,
  input  logic        mem_write_en,
  input  logic        is_word,
  input  logic [31:0] alu_result,
  input  logic [31:0] read_data_2,
  output logic        cache_done,
  output logic [31:0] mem_read_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_valid;
  logic [26:0] r_tag  [8];
  logic [31:0] r_data [8];
  logic [31:0] r_result;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic [2:0]  w_index;
  logic [26:0] w_tag;
  logic [1:0]  w_lane;
  logic        w_hit;
  logic [31:0] w_line;
  logic [31:0] w_hit_data;

  assign w_index = alu_result[4:2];
  assign w_tag   = alu_result[31:5];
  assign w_lane  = alu_result[1:0];
  assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_line  = r_data[w_index];

  // Zero-extended byte or full word, as a load of this access would return it.
  function automatic logic [31:0] load_view(input logic [31:0] word, input logic [1:0] lane,
                                            input logic whole);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    return whole ? word : {24'b0, shifted[7:0]};
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [7:0] b,
                                             input logic [1:0] lane);
    logic [31:0] merged;
    merged = word;
    merged[{lane, 3'b000} +: 8] = b;
    return merged;
  endfunction

  assign w_hit_data = load_view(w_line, w_lane, is_word);

  // Stall is combinational in IDLE so the pipeline freezes in the same cycle a miss/store is seen.
  assign cache_done = ((r_state == IDLE) && is_mem_inst && (mem_write_en || !w_hit)) ||
                      (r_state == MEM_RD) || (r_state == MEM_WR);

  assign mem_read_data = (r_state == DONE) ? r_result :
                         ((r_state == IDLE) && is_mem_inst && !mem_write_en && w_hit) ? w_hit_data :
                         32'h0;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_result    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      for (int i = 0; i < 8; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (is_mem_inst && mem_write_en) begin
            r_state     <= MEM_WR;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {alu_result[31:2], 2'b00};
            r_mem_wdata <= is_word ? read_data_2 : {4{read_data_2[7:0]}};
            r_mem_wstrb <= is_word ? 4'b1111 : (4'b0001 << w_lane);
            if (w_hit)
              r_data[w_index] <= is_word ? read_data_2 : merge_byte(w_line, read_data_2[7:0], w_lane);
          end else if (is_mem_inst && !w_hit) begin
            r_state     <= MEM_RD;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {alu_result[31:2], 2'b00};
            r_mem_wstrb <= 4'b0000;
          end
        end
        MEM_RD: begin
          if (mem_ready) begin
            r_state          <= DONE;
            r_mem_req        <= 1'b0;
            r_valid[w_index] <= 1'b1;
            r_tag[w_index]   <= w_tag;
            r_data[w_index]  <= mem_rdata;
            r_result         <= load_view(mem_rdata, w_lane, is_word);
          end
        end
        MEM_WR: begin
          if (mem_ready) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed, table-driven bench for dcache_ctrl with a bounded backing-memory responder.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst_b;
  logic        is_mem_inst;
  logic        mem_write_en;
  logic        is_word;
  logic [31:0] alu_result;
  logic [31:0] read_data_2;
  logic        cache_done;
  logic [31:0] mem_read_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_assert;
  int n_fail;

  dcache_ctrl dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .is_mem_inst   (is_mem_inst),
    .mem_write_en  (mem_write_en),
    .is_word       (is_word),
    .alu_result    (alu_result),
    .read_data_2   (read_data_2),
    .cache_done    (cache_done),
    .mem_read_data (mem_read_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  // Clock / timeout
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;        // 1 = store
    logic        wd;        // 1 = word
    logic [31:0] addr;
    logic [31:0] wdat;
    int          lat;       // MEM_* cycle in which mem_ready is given; 0 = hit, no request expected
    logic [31:0] mrd;       // memory read data returned with mem_ready
    int          exp_stall;
    logic [31:0] exp_rd;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic st, input logic wd, input logic [31:0] addr,
                              input logic [31:0] wdat, input int lat, input logic [31:0] mrd,
                              input int stall, input logic [31:0] rd, input logic [3:0] strb,
                              input logic [31:0] wdata);
    vec_t v;
    v.st = st; v.wd = wd; v.addr = addr; v.wdat = wdat; v.lat = lat; v.mrd = mrd;
    v.exp_stall = stall; v.exp_rd = rd; v.exp_strb = strb; v.exp_wdata = wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present one access, act as backing memory, measure the stall, check the result.
  task automatic run_vec(input vec_t v, input int id);
    int  stall;
    int  memcyc;
    bit  fin;
    int  c;
    @(negedge clk);
    is_mem_inst  = 1'b1;
    mem_write_en = v.st;
    is_word      = v.wd;
    alu_result   = v.addr;
    read_data_2  = v.wdat;
    mem_ready    = 1'b0;
    mem_rdata    = 32'hBAD0BAD0;
    #1;
    stall = 0; memcyc = 0; fin = 1'b0; c = 0;
    while (!fin && c < 40) begin
      if (!cache_done) begin
        fin = 1'b1;
      end else begin
        stall++;
        if (mem_req) begin
          memcyc++;
          chk($sformatf("v%0d mem_addr", id), mem_addr, {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d mem_we", id), {31'b0, mem_we}, {31'b0, v.st});
          if (v.st) begin
            chk($sformatf("v%0d mem_wstrb", id), {28'b0, mem_wstrb}, {28'b0, v.exp_strb});
            chk($sformatf("v%0d mem_wdata", id), mem_wdata, v.exp_wdata);
          end
          mem_ready = (memcyc == v.lat);
          mem_rdata = (memcyc == v.lat) ? v.mrd : 32'hBAD0BAD0;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        #1;
        c++;
      end
    end
    if (!fin) begin
      n_assert++;
      n_fail++;
      $display("FAIL v%0d timeout: cache_done still 1 after %0d cycles, expected stall %0d",
               id, c, v.exp_stall);
    end
    chk($sformatf("v%0d stall", id), stall, v.exp_stall);
    chk($sformatf("v%0d mem_cycles", id), memcyc, v.lat);
    chk($sformatf("v%0d mem_req_idle", id), {31'b0, mem_req}, 32'h0);
    if (!v.st) chk($sformatf("v%0d read_data", id), mem_read_data, v.exp_rd);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    //            st  wd  addr         wdat          lat mrd           stall rd            strb     wdata
    vecs[0]  = mk(0, 1, 32'h100, 32'h0,        3, 32'hDEADBEEF, 4, 32'hDEADBEEF, 4'h0, 32'h0);
    vecs[1]  = mk(0, 1, 32'h100, 32'h0,        0, 32'h0,        0, 32'hDEADBEEF, 4'h0, 32'h0);
    vecs[2]  = mk(1, 0, 32'h102, 32'hAA,       1, 32'h0,        2, 32'h0,        4'b0100, 32'hAAAAAAAA);
    vecs[3]  = mk(0, 0, 32'h102, 32'h0,        0, 32'h0,        0, 32'h000000AA, 4'h0, 32'h0);
    vecs[4]  = mk(0, 1, 32'h100, 32'h0,        0, 32'h0,        0, 32'hDEAABEEF, 4'h0, 32'h0);
    vecs[5]  = mk(0, 1, 32'h120, 32'h0,        1, 32'h12345678, 2, 32'h12345678, 4'h0, 32'h0);
    vecs[6]  = mk(0, 1, 32'h100, 32'h0,        2, 32'hCAFEF00D, 3, 32'hCAFEF00D, 4'h0, 32'h0);
    vecs[7]  = mk(1, 1, 32'h200, 32'h55667788, 2, 32'h0,        3, 32'h0,        4'hF, 32'h55667788);
    vecs[8]  = mk(0, 1, 32'h100, 32'h0,        0, 32'h0,        0, 32'hCAFEF00D, 4'h0, 32'h0);
    vecs[9]  = mk(0, 1, 32'h200, 32'h0,        1, 32'hA5A5A5A5, 2, 32'hA5A5A5A5, 4'h0, 32'h0);
    vecs[10] = mk(0, 1, 32'h204, 32'h0,        1, 32'h99AABBCC, 2, 32'h99AABBCC, 4'h0, 32'h0);
    vecs[11] = mk(0, 0, 32'h207, 32'h0,        0, 32'h0,        0, 32'h00000099, 4'h0, 32'h0);
    vecs[12] = mk(0, 0, 32'h205, 32'h0,        0, 32'h0,        0, 32'h000000BB, 4'h0, 32'h0);
    vecs[13] = mk(1, 0, 32'h304, 32'h1234567F, 1, 32'h0,        2, 32'h0,        4'b0001, 32'h7F7F7F7F);
    vecs[14] = mk(0, 1, 32'h204, 32'h0,        0, 32'h0,        0, 32'h99AABBCC, 4'h0, 32'h0);
    vecs[15] = mk(1, 1, 32'h206, 32'h11223344, 3, 32'h0,        4, 32'h0,        4'hF, 32'h11223344);
    vecs[16] = mk(0, 1, 32'h204, 32'h0,        0, 32'h0,        0, 32'h11223344, 4'h0, 32'h0);
    vecs[17] = mk(0, 0, 32'h200, 32'h0,        0, 32'h0,        0, 32'h000000A5, 4'h0, 32'h0);
    vecs[18] = mk(1, 0, 32'h207, 32'hEE,       1, 32'h0,        2, 32'h0,        4'b1000, 32'hEEEEEEEE);
    vecs[19] = mk(0, 1, 32'h204, 32'h0,        0, 32'h0,        0, 32'hEE223344, 4'h0, 32'h0);
    // after a reset abandoning a fill of 0x140: everything misses
    vecs[20] = mk(0, 1, 32'h140, 32'h0,        1, 32'h01020304, 2, 32'h01020304, 4'h0, 32'h0);
    vecs[21] = mk(0, 1, 32'h204, 32'h0,        1, 32'h0BADF00D, 2, 32'h0BADF00D, 4'h0, 32'h0);

    // Reset
    rst_b        = 1'b0;
    is_mem_inst  = 1'b0;
    mem_write_en = 1'b0;
    is_word      = 1'b0;
    alu_result   = 32'h0;
    read_data_2  = 32'h0;
    mem_ready    = 1'b0;
    mem_rdata    = 32'h0;
    #23;
    chk("rst cache_done", {31'b0, cache_done}, 32'h0);
    chk("rst mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("rst read_data", mem_read_data, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    #1;
    chk("idle no access cache_done", {31'b0, cache_done}, 32'h0);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // Reset in the middle of a MEM_RD, then a stray mem_ready
    @(negedge clk);
    is_mem_inst  = 1'b1;
    mem_write_en = 1'b0;
    is_word      = 1'b1;
    alu_result   = 32'h140;
    #1;
    chk("midrst miss stall", {31'b0, cache_done}, 32'h1);
    @(negedge clk);
    #1;
    chk("midrst mem_req", {31'b0, mem_req}, 32'h1);
    rst_b = 1'b0;
    #1;
    chk("midrst req dropped", {31'b0, mem_req}, 32'h0);
    chk("midrst mem_addr", mem_addr, 32'h0);
    chk("midrst mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    is_mem_inst = 1'b0;
    #1;
    chk("midrst cache_done", {31'b0, cache_done}, 32'h0);
    @(negedge clk);
    rst_b     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h77777777;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("stray ready mem_req", {31'b0, mem_req}, 32'h0);
    chk("stray ready cache_done", {31'b0, cache_done}, 32'h0);

    for (int i = 20; i < 22; i++) run_vec(vecs[i], i);

    @(negedge clk);
    is_mem_inst = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
